mtm_alu_deserializer: RTL and testbench



---
 rtl/mtm_alu_pkg.sv | 42 ++++
 rtl/mtm_alu_deserializer.sv | 125 ++++++++++++
 tb/tb_mtm_alu_deserializer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mtm_alu_pkg.sv
// +----------------------------------------------------------------------+
// | mtm_alu_pkg                                                          |
// | Shared frame, opcode and FSM constants plus the packet CRC4 helper.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package mtm_alu_pkg;

  localparam logic FT_DATA = 1'b0;
  localparam logic FT_CMD  = 1'b1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_TYPE   = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd3;
  localparam logic [2:0] ST_RESYNC = 3'd4;

  // Serial LFSR form of x^4+x+1, zero seed, message bit 67 enters first.
  function automatic logic [3:0] crc4_68(input logic [67:0] data);
    logic [3:0] crc;
    logic       fb;
    crc = 4'b0000;
    for (int i = 67; i >= 0; i--) begin
      fb  = crc[3] ^ data[i];
      crc = {crc[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return crc;
  endfunction

  function automatic logic op_supported(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mtm_alu_deserializer.sv
// +----------------------------------------------------------------------+
// | mtm_alu_deserializer                                                 |
// | Serial frame receiver and packet checker feeding the MTM ALU core.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module mtm_alu_deserializer
  import mtm_alu_pkg::*;
#(
  parameter int DATA_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [2:0]  OP,
  output logic        valid,
  output logic        err_data,
  output logic        err_crc,
  output logic        err_op
);

  localparam int CNT_W = $clog2(DATA_FRAMES + 1);
  localparam logic [CNT_W-1:0] c_frames_full = CNT_W'(DATA_FRAMES);

  logic [2:0]       r_state;
  logic             r_type;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic [CNT_W-1:0] r_frame_cnt;
  logic             r_bad;
  logic [63:0]      r_buf;

  logic [2:0] w_cmd_op;
  logic       w_pkt_bad;
  logic       w_crc_ok;

  // While in STOP the shift register holds the complete command byte.
  assign w_cmd_op  = r_shift[6:4];
  assign w_pkt_bad = r_bad || (r_frame_cnt != c_frames_full) || r_shift[7];
  assign w_crc_ok  = (r_shift[3:0] == crc4_68({r_buf, 1'b1, w_cmd_op}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_type      <= FT_DATA;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'd0;
      r_frame_cnt <= '0;
      r_bad       <= 1'b0;
      r_buf       <= 64'd0;
      A           <= 32'd0;
      B           <= 32'd0;
      OP          <= 3'd0;
      valid       <= 1'b0;
      err_data    <= 1'b0;
      err_crc     <= 1'b0;
      err_op      <= 1'b0;
    end else begin
      valid    <= 1'b0;
      err_data <= 1'b0;
      err_crc  <= 1'b0;
      err_op   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!sin) r_state <= ST_TYPE;
        end
        ST_TYPE: begin
          r_type    <= sin;
          r_bit_cnt <= 3'd0;
          r_state   <= ST_DATA;
        end
        ST_DATA: begin
          r_shift   <= {r_shift[6:0], sin};
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) r_state <= ST_STOP;
        end
        ST_STOP: begin
          if (sin) begin
            r_state <= ST_IDLE;
            if (r_type == FT_DATA) begin
              // Bytes arrive B[31:24] first, so shifting leaves {B, A} in place.
              if (r_frame_cnt < c_frames_full) begin
                r_buf       <= {r_buf[55:0], r_shift};
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
              end else begin
                r_bad <= 1'b1;
              end
            end else begin
              r_frame_cnt <= '0;
              r_bad       <= 1'b0;
              if (w_pkt_bad) begin
                err_data <= 1'b1;
              end else if (!w_crc_ok) begin
                err_crc <= 1'b1;
              end else if (!op_supported(w_cmd_op)) begin
                err_op <= 1'b1;
              end else begin
                valid <= 1'b1;
                B     <= r_buf[63:32];
                A     <= r_buf[31:0];
                OP    <= w_cmd_op;
              end
            end
          end else begin
            err_data    <= 1'b1;
            r_frame_cnt <= '0;
            r_bad       <= 1'b0;
            r_state     <= ST_RESYNC;
          end
        end
        ST_RESYNC: begin
          // A held-low line must return high before a start bit is accepted.
          if (sin) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mtm_alu_deserializer.sv
// +----------------------------------------------------------------------+
// | tb_mtm_alu_deserializer                                              |
// | Directed and randomized checks of the MTM ALU deserializer.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mtm_alu_deserializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sin;
  logic [31:0] A, B;
  logic [2:0]  OP;
  logic        valid, err_data, err_crc, err_op;

  mtm_alu_deserializer #(.DATA_FRAMES(8)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin),
    .A(A), .B(B), .OP(OP),
    .valid(valid), .err_data(err_data), .err_crc(err_crc), .err_op(err_op)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int n_valid, n_data, n_crc, n_op;
  int valid_cyc, data_cyc, last_stop_cyc;
  logic [66:0] cap_q[$];
  logic [31:0] exp_a, exp_b;
  logic [2:0]  exp_op;

  // Pulse recorder: counts every high cycle of each strobe.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin
        n_valid++;
        valid_cyc = cyc;
        cap_q.push_back({B, A, OP});
      end
      if (err_data) begin
        n_data++;
        data_cyc = cyc;
      end
      if (err_crc) n_crc++;
      if (err_op)  n_op++;
    end
  end

  // Remainder of M(x)*x^4 divided by x^4+x+1, by long division.
  function automatic logic [3:0] ref_crc(input logic [67:0] m);
    logic [71:0] r;
    r = {m, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  function automatic logic [7:0] make_cmd(input logic [2:0] op, input logic [31:0] b,
                                          input logic [31:0] a, input logic [3:0] flip,
                                          input logic bit7);
    return {bit7, op, ref_crc({b, a, 1'b1, op}) ^ flip};
  endfunction

  // 0 valid, 1 err_data, 2 err_crc, 3 err_op
  function automatic int model_outcome(input int nframes, input logic [31:0] b,
                                       input logic [31:0] a, input logic [7:0] cmd);
    if (nframes != 8 || cmd[7]) return 1;
    if (cmd[3:0] != ref_crc({b, a, 1'b1, cmd[6:4]})) return 2;
    if (!(cmd[6:4] inside {3'b000, 3'b001, 3'b100, 3'b101})) return 3;
    return 0;
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk);
    sin = b;
  endtask

  task automatic idle(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic t, input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    send_bit(t);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(stop);
    last_stop_cyc = cyc + 1;
  endtask

  task automatic send_packet(input logic [31:0] b, input logic [31:0] a,
                             input int nframes, input logic [7:0] cmd);
    logic [63:0] ba;
    ba = {b, a};
    for (int k = 0; k < nframes; k++) begin
      if (k < 8) send_frame(1'b0, ba[63 - 8*k -: 8], 1'b1);
      else       send_frame(1'b0, 8'($urandom), 1'b1);
    end
    send_frame(1'b1, cmd, 1'b1);
  endtask

  task automatic clear_counts();
    n_valid = 0; n_data = 0; n_crc = 0; n_op = 0;
    valid_cyc = -1; data_cyc = -1;
    cap_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sin   = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({A, B, OP} !== 67'd0) begin
      errors++;
      $display("FAIL reset_regs got A=%h B=%h OP=%b want 0", A, B, OP);
    end
    checks++;
    if ({valid, err_data, err_crc, err_op} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000", {valid, err_data, err_crc, err_op});
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
    idle(4);
    #1;
    checks++;
    if (n_valid + n_data + n_crc + n_op !== 0) begin
      errors++;
      $display("FAIL reset_idle_flags got %0d pulses want 0", n_valid + n_data + n_crc + n_op);
    end
    exp_a = 0; exp_b = 0; exp_op = 0;
  endtask

  task automatic test_good_add();
    clear_counts();
    send_packet(32'h2, 32'h1, 8, make_cmd(3'b100, 32'h2, 32'h1, 4'h0, 1'b0));
    idle(3);
    #1;
    checks++;
    if (n_valid !== 1 || n_data !== 0 || n_crc !== 0 || n_op !== 0) begin
      errors++;
      $display("FAIL good_add_flags got v%0d d%0d c%0d o%0d want v1 d0 c0 o0", n_valid, n_data, n_crc, n_op);
    end
    checks++;
    if (valid_cyc !== last_stop_cyc) begin
      errors++;
      $display("FAIL good_add_latency got cycle %0d want %0d", valid_cyc, last_stop_cyc);
    end
    checks++;
    if ({A, B, OP} !== {32'h1, 32'h2, 3'b100}) begin
      errors++;
      $display("FAIL good_add_data got A=%h B=%h OP=%b want A=1 B=2 OP=100", A, B, OP);
    end
    exp_a = 32'h1; exp_b = 32'h2; exp_op = 3'b100;
  endtask

  task automatic test_wrong_crc();
    logic [31:0] bs[2];
    logic [31:0] as[2];
    bs[0] = 32'h2; as[0] = 32'h1;
    bs[1] = 32'hA5A5_1234; as[1] = 32'h0BAD_F00D;
    for (int i = 0; i < 2; i++) begin
      clear_counts();
      send_packet(bs[i], as[i], 8, make_cmd(3'b100, bs[i], as[i], 4'b0001, 1'b0));
      idle(3);
      #1;
      checks++;
      if (n_valid !== 0 || n_data !== 0 || n_crc !== 1 || n_op !== 0) begin
        errors++;
        $display("FAIL wrong_crc_flags[%0d] got v%0d d%0d c%0d o%0d want v0 d0 c1 o0", i, n_valid, n_data, n_crc, n_op);
      end
      checks++;
      if ({A, B, OP} !== {exp_a, exp_b, exp_op}) begin
        errors++;
        $display("FAIL wrong_crc_hold[%0d] got A=%h B=%h OP=%b want A=%h B=%h OP=%b", i, A, B, OP, exp_a, exp_b, exp_op);
      end
    end
  endtask

  task automatic test_bad_op();
    clear_counts();
    send_packet(32'h3, 32'h4, 8, make_cmd(3'b111, 32'h3, 32'h4, 4'h0, 1'b0));
    idle(3);
    #1;
    checks++;
    if (n_valid !== 0 || n_data !== 0 || n_crc !== 0 || n_op !== 1) begin
      errors++;
      $display("FAIL bad_op_flags got v%0d d%0d c%0d o%0d want v0 d0 c0 o1", n_valid, n_data, n_crc, n_op);
    end
    checks++;
    if ({A, B, OP} !== {exp_a, exp_b, exp_op}) begin
      errors++;
      $display("FAIL bad_op_hold got A=%h B=%h OP=%b want A=%h B=%h OP=%b", A, B, OP, exp_a, exp_b, exp_op);
    end
  endtask

  task automatic test_count_errors();
    int nf[2];
    nf[0] = 7; nf[1] = 9;
    for (int i = 0; i < 2; i++) begin
      clear_counts();
      send_packet(32'h11, 32'h22, nf[i], make_cmd(3'b000, 32'h11, 32'h22, 4'h0, 1'b0));
      idle(3);
      #1;
      checks++;
      if (n_valid !== 0 || n_data !== 1 || n_crc !== 0 || n_op !== 0) begin
        errors++;
        $display("FAIL count_%0d_flags got v%0d d%0d c%0d o%0d want v0 d1 c0 o0", nf[i], n_valid, n_data, n_crc, n_op);
      end
    end
    clear_counts();
    send_packet(32'hDEAD_BEEF, 32'h1234_5678, 8, make_cmd(3'b101, 32'hDEAD_BEEF, 32'h1234_5678, 4'h0, 1'b0));
    idle(3);
    #1;
    checks++;
    if (n_valid !== 1 || n_data !== 0 || n_crc !== 0 || n_op !== 0) begin
      errors++;
      $display("FAIL count_recover_flags got v%0d d%0d c%0d o%0d want v1 d0 c0 o0", n_valid, n_data, n_crc, n_op);
    end
    checks++;
    if ({A, B, OP} !== {32'h1234_5678, 32'hDEAD_BEEF, 3'b101}) begin
      errors++;
      $display("FAIL count_recover_data got A=%h B=%h OP=%b want A=12345678 B=deadbeef OP=101", A, B, OP);
    end
    exp_a = 32'h1234_5678; exp_b = 32'hDEAD_BEEF; exp_op = 3'b101;
  endtask

  task automatic test_framing();
    int stop_c;
    clear_counts();
    send_frame(1'b0, 8'h0F, 1'b1);
    send_frame(1'b0, 8'h0F, 1'b1);
    send_frame(1'b0, 8'h0F, 1'b0);
    stop_c = last_stop_cyc;
    repeat (5) send_bit(1'b0);
    idle(4);
    #1;
    checks++;
    if (n_valid !== 0 || n_data !== 1 || n_crc !== 0 || n_op !== 0) begin
      errors++;
      $display("FAIL framing_flags got v%0d d%0d c%0d o%0d want v0 d1 c0 o0", n_valid, n_data, n_crc, n_op);
    end
    checks++;
    if (data_cyc !== stop_c) begin
      errors++;
      $display("FAIL framing_when got cycle %0d want %0d", data_cyc, stop_c);
    end
    clear_counts();
    send_packet(32'h0F0F_0F0F, 32'hF0F0_F0F0, 8, make_cmd(3'b001, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 4'h0, 1'b0));
    idle(3);
    #1;
    checks++;
    if (n_valid !== 1 || n_data !== 0 || n_crc !== 0 || n_op !== 0) begin
      errors++;
      $display("FAIL framing_recover_flags got v%0d d%0d c%0d o%0d want v1 d0 c0 o0", n_valid, n_data, n_crc, n_op);
    end
    checks++;
    if ({A, B, OP} !== {32'hF0F0_F0F0, 32'h0F0F_0F0F, 3'b001}) begin
      errors++;
      $display("FAIL framing_recover_data got A=%h B=%h OP=%b want A=f0f0f0f0 B=0f0f0f0f OP=001", A, B, OP);
    end
    exp_a = 32'hF0F0_F0F0; exp_b = 32'h0F0F_0F0F; exp_op = 3'b001;
  endtask

  task automatic test_back_to_back();
    clear_counts();
    send_packet(32'h0000_00AA, 32'h5500_0000, 8, make_cmd(3'b000, 32'h0000_00AA, 32'h5500_0000, 4'h0, 1'b0));
    send_packet(32'h7777_8888, 32'h9999_AAAA, 8, make_cmd(3'b100, 32'h7777_8888, 32'h9999_AAAA, 4'h0, 1'b0));
    idle(3);
    #1;
    checks++;
    if (n_valid !== 2 || n_data !== 0 || n_crc !== 0 || n_op !== 0) begin
      errors++;
      $display("FAIL b2b_flags got v%0d d%0d c%0d o%0d want v2 d0 c0 o0", n_valid, n_data, n_crc, n_op);
    end
    checks++;
    if (cap_q.size() !== 2 || cap_q[0] !== {32'h0000_00AA, 32'h5500_0000, 3'b000}) begin
      errors++;
      $display("FAIL b2b_first got %0d captures, first %h", cap_q.size(), cap_q.size() > 0 ? cap_q[0] : 67'd0);
    end
    checks++;
    if ({A, B, OP} !== {32'h9999_AAAA, 32'h7777_8888, 3'b100}) begin
      errors++;
      $display("FAIL b2b_second got A=%h B=%h OP=%b want A=9999aaaa B=77778888 OP=100", A, B, OP);
    end
    exp_a = 32'h9999_AAAA; exp_b = 32'h7777_8888; exp_op = 3'b100;
  endtask

  task automatic test_reset_mid();
    clear_counts();
    for (int k = 0; k < 4; k++) send_frame(1'b0, 8'hC3, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    sin   = 1'b1;
    #1;
    checks++;
    if ({A, B, OP, valid, err_data, err_crc, err_op} !== 71'd0) begin
      errors++;
      $display("FAIL reset_mid_clear got A=%h B=%h OP=%b flags=%b want all 0", A, B, OP, {valid, err_data, err_crc, err_op});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_a = 0; exp_b = 0; exp_op = 0;
    idle(4);
    #1;
    checks++;
    if (n_valid + n_data + n_crc + n_op !== 0) begin
      errors++;
      $display("FAIL reset_mid_noflag got %0d pulses want 0", n_valid + n_data + n_crc + n_op);
    end
    send_packet(32'hCAFE_0001, 32'h0000_BABE, 8, make_cmd(3'b101, 32'hCAFE_0001, 32'h0000_BABE, 4'h0, 1'b0));
    idle(3);
    #1;
    checks++;
    if (n_valid !== 1 || n_data !== 0 || n_crc !== 0 || n_op !== 0 ||
        {A, B, OP} !== {32'h0000_BABE, 32'hCAFE_0001, 3'b101}) begin
      errors++;
      $display("FAIL reset_mid_recover got v%0d d%0d c%0d o%0d A=%h B=%h OP=%b want v1 A=0000babe B=cafe0001 OP=101",
               n_valid, n_data, n_crc, n_op, A, B, OP);
    end
    exp_a = 32'h0000_BABE; exp_b = 32'hCAFE_0001; exp_op = 3'b101;
  endtask

  task automatic test_random();
    logic [31:0] b, a;
    logic [2:0]  op;
    logic [3:0]  flip;
    logic        bit7;
    logic [7:0]  cmd;
    int          nf, sel, outc;
    int          ev, ed, ec, eo;
    for (int it = 0; it < 40; it++) begin
      b    = $urandom;
      a    = $urandom;
      op   = 3'($urandom_range(0, 7));
      sel  = $urandom_range(0, 9);
      nf   = (sel == 0) ? 7 : (sel == 1) ? 9 : 8;
      flip = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      bit7 = ($urandom_range(0, 9) == 0);
      cmd  = make_cmd(op, b, a, flip, bit7);
      outc = model_outcome(nf, b, a, cmd);
      ev = (outc == 0); ed = (outc == 1); ec = (outc == 2); eo = (outc == 3);
      if (outc == 0) begin
        exp_a = a; exp_b = b; exp_op = op;
      end
      clear_counts();
      send_packet(b, a, nf, cmd);
      idle(2 + $urandom_range(0, 2));
      #1;
      checks++;
      if (n_valid !== ev || n_data !== ed || n_crc !== ec || n_op !== eo) begin
        errors++;
        $display("FAIL rand[%0d]_flags got v%0d d%0d c%0d o%0d want v%0d d%0d c%0d o%0d",
                 it, n_valid, n_data, n_crc, n_op, ev, ed, ec, eo);
      end
      checks++;
      if ({A, B, OP} !== {exp_a, exp_b, exp_op}) begin
        errors++;
        $display("FAIL rand[%0d]_data got A=%h B=%h OP=%b want A=%h B=%h OP=%b",
                 it, A, B, OP, exp_a, exp_b, exp_op);
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_add();
    test_wrong_crc();
    test_bad_op();
    test_count_errors();
    test_framing();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
